// File: rtl/dmem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dmem_responder : single-outstanding data-memory responder with wait states  |
// | Optional DMEM_PERF_CNT_EN adds completed read/write counters.  Rev 1.0      |
// +-----------------------------------------------------------------------------+
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_v,
    input  logic        w_v,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_strobe,
    output logic        hit,
    output logic [15:0] mem_res,
    output logic        mem_res_error,
    output logic        busy,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int          c_AW     = $clog2(DEPTH);
    localparam logic [32:0] c_LIMIT  = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  c_LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [c_AW-1:0]   r_idx;
    logic [31:0]       r_data;
    logic [3:0]        r_strb;
    logic              r_wr;
    logic              r_err;
    logic              w_req;
    logic              w_err;
    logic              w_commit;
    logic [31:0]       w_word;
    logic [15:0]       w_rdata;
    logic [31:0]       r_mem [DEPTH];

    assign w_req    = r_v | w_v;
    assign busy     = (r_state != IDLE);
    assign w_commit = (r_state == RESP) && r_wr && !r_err && !rst;
    assign w_word   = r_mem[r_idx];

    // Strobe must be a contiguous lane group, naturally aligned for half/word.
    always_comb begin
        w_err = (r_v & w_v) | ({1'b0, req_adr} >= c_LIMIT);
        case (req_strobe)
            4'b1111:                   w_err = w_err | (req_adr[1:0] != 2'd0);
            4'b0011, 4'b0110, 4'b1100: w_err = w_err | req_adr[0] | (req_adr[1:0] == 2'd3);
            4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0111, 4'b1110: w_err = w_err;
            default:                   w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_rdata = w_word[15:0];
        case (r_strb)
            4'b0001: w_rdata = {8'h00, w_word[7:0]};
            4'b0010: w_rdata = {8'h00, w_word[15:8]};
            4'b0100: w_rdata = {8'h00, w_word[23:16]};
            4'b1000: w_rdata = {8'h00, w_word[31:24]};
            4'b0110: w_rdata = w_word[23:8];
            4'b1100: w_rdata = w_word[31:16];
            default: w_rdata = w_word[15:0];
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (r_cnt == 4'd0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= 4'd0;
            r_idx         <= '0;
            r_data        <= 32'd0;
            r_strb        <= 4'd0;
            r_wr          <= 1'b0;
            r_err         <= 1'b0;
            hit           <= 1'b0;
            mem_res       <= 16'd0;
            mem_res_error <= 1'b0;
        end else begin
            r_state <= w_next;
            hit     <= 1'b0;
            if (r_state == IDLE && w_req) begin
                r_cnt  <= c_LAT_M1;
                r_idx  <= req_adr[2 +: c_AW];
                r_data <= req_data;
                r_strb <= req_strobe;
                r_wr   <= w_v;
                r_err  <= w_err;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Response registers update on the same edge that commits a write.
            if (r_state == RESP) begin
                hit           <= 1'b1;
                mem_res_error <= r_err;
                mem_res       <= (r_err || r_wr) ? 16'd0 : w_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_strb[i]) r_mem[r_idx][8*i +: 8] <= r_data[8*i +: 8];
            end
        end
    end

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_cnt <= 32'd0;
            r_wr_cnt <= 32'd0;
        end else if (r_state == RESP && !r_err) begin
            if (r_wr) r_wr_cnt <= r_wr_cnt + 32'd1;
            else      r_rd_cnt <= r_rd_cnt + 32'd1;
        end
    end

    assign rd_count = r_rd_cnt;
    assign wr_count = r_wr_cnt;
`else
    assign rd_count = 32'd0;
    assign wr_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_dmem_responder : three responders (LATENCY 1, 3, 0) against a reference  |
// | model of the memory, error rules and counters.  Rev 1.0                     |
// +-----------------------------------------------------------------------------+
module tb_dmem_responder;

    localparam int NI    = 3;
    localparam int DEPTH = 64;
`ifdef DMEM_PERF_CNT_EN
    localparam bit c_PERF = 1'b1;
`else
    localparam bit c_PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        r_v        [NI];
    logic        w_v        [NI];
    logic [31:0] req_adr    [NI];
    logic [31:0] req_data   [NI];
    logic [3:0]  req_strobe [NI];
    logic        hit        [NI];
    logic [15:0] mem_res    [NI];
    logic        mem_res_error [NI];
    logic        busy       [NI];
    logic [31:0] rd_count   [NI];
    logic [31:0] wr_count   [NI];

    logic [31:0] m_mem [NI][DEPTH];
    int unsigned m_rd [NI];
    int unsigned m_wr [NI];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int c_LAT = (gi == 0) ? 1 : ((gi == 1) ? 3 : 0);
        dmem_responder #(.DEPTH(DEPTH), .LATENCY(c_LAT)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .r_v          (r_v[gi]),
            .w_v          (w_v[gi]),
            .req_adr      (req_adr[gi]),
            .req_data     (req_data[gi]),
            .req_strobe   (req_strobe[gi]),
            .hit          (hit[gi]),
            .mem_res      (mem_res[gi]),
            .mem_res_error(mem_res_error[gi]),
            .busy         (busy[gi]),
            .rd_count     (rd_count[gi]),
            .wr_count     (wr_count[gi])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Error rules stated on the access itself: lane group shape and alignment.
    function automatic bit m_err(input bit rv, input bit wv, input logic [31:0] adr,
                                 input logic [3:0] s);
        int n;
        int lo;
        n = $countones(s);
        if (rv && wv) return 1'b1;
        if (adr >= 32'(DEPTH * 4)) return 1'b1;
        if (n == 0) return 1'b1;
        lo = 0;
        while (!s[lo]) lo++;
        if (int'(s >> lo) != ((1 << n) - 1)) return 1'b1;
        if (n == 4 && adr[1:0] != 2'd0) return 1'b1;
        if (n == 2 && adr[0]) return 1'b1;
        return 1'b0;
    endfunction

    // Enabled bytes packed low-lane-first, truncated to 16 bits.
    function automatic logic [15:0] m_read(input logic [31:0] word, input logic [3:0] s);
        logic [15:0] r;
        int k;
        r = 16'd0;
        k = 0;
        for (int lane = 0; lane < 4; lane++) begin
            if (s[lane] && k < 2) begin
                r[8*k +: 8] = word[8*lane +: 8];
                k++;
            end
        end
        return r;
    endfunction

    task automatic drive(input int d, input bit rv, input bit wv, input logic [31:0] adr,
                         input logic [31:0] data, input logic [3:0] s);
        r_v[d]        = rv;
        w_v[d]        = wv;
        req_adr[d]    = adr;
        req_data[d]   = data;
        req_strobe[d] = s;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge showing the hit.
    task automatic xact(input int d, input bit rv, input bit wv, input logic [31:0] adr,
                        input logic [31:0] data, input logic [3:0] s, input bit drop,
                        input string tag);
        bit          e;
        int          idx;
        int          lat;
        logic [15:0] exp_res;
        lat     = lat_of(d);
        e       = m_err(rv, wv, adr, s);
        idx     = int'((adr >> 2) % DEPTH);
        exp_res = (!e && rv && !wv) ? m_read(m_mem[d][idx], s) : 16'd0;
        drive(d, rv, wv, adr, data, s);
        @(posedge clk);
        @(negedge clk);
        if (drop) drive(d, 1'b0, 1'b1, adr ^ 32'h4, 32'hFFFF_FFFF, 4'hF);
        else      drive(d, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        for (int k = 0; k <= lat; k++) begin
            check({tag, "_busy"}, busy[d], 1);
            check({tag, "_early_hit"}, hit[d], 0);
            @(negedge clk);
            drive(d, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        end
        check({tag, "_hit"}, hit[d], 1);
        check({tag, "_idle"}, busy[d], 0);
        check({tag, "_err"}, mem_res_error[d], e);
        check({tag, "_res"}, mem_res[d], exp_res);
        if (!e && wv) begin
            for (int lane = 0; lane < 4; lane++)
                if (s[lane]) m_mem[d][idx][8*lane +: 8] = data[8*lane +: 8];
        end
        if (!e) begin
            if (wv) m_wr[d]++;
            else    m_rd[d]++;
        end
        check({tag, "_rd_count"}, rd_count[d], c_PERF ? m_rd[d] : 0);
        check({tag, "_wr_count"}, wr_count[d], c_PERF ? m_wr[d] : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit          rv;
        bit          wv;
        logic [31:0] adr;
        logic [3:0]  s;
        int          d;
        int          p;

        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            drive(i, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
            m_rd[i] = 0;
            m_wr[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_hit", hit[i], 0);
            check("rst_err", mem_res_error[i], 0);
            check("rst_res", mem_res[i], 0);
            check("rst_busy", busy[i], 0);
            check("rst_rd_count", rd_count[i], 0);
            check("rst_wr_count", wr_count[i], 0);
        end
        rst = 1'b0;

        for (int i = 0; i < NI; i++)
            for (int w = 0; w < DEPTH; w++)
                xact(i, 1'b0, 1'b1, 32'(w * 4), $urandom(), 4'hF, 1'b0, "init");

        xact(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0, "wr_word");
        xact(0, 1'b1, 1'b0, 32'h10, 32'd0, 4'b1111, 1'b0, "rd_word");
        xact(0, 1'b0, 1'b1, 32'h13, 32'hAA00_0000, 4'b1000, 1'b0, "wr_byte");
        xact(0, 1'b1, 1'b0, 32'h12, 32'd0, 4'b1100, 1'b0, "rd_half");
        xact(0, 1'b1, 1'b0, 32'h11, 32'd0, 4'b1111, 1'b0, "rd_misalign");
        xact(0, 1'b0, 1'b1, 32'(DEPTH * 4), 32'h1234_5678, 4'b1111, 1'b0, "wr_oor");
        xact(0, 1'b1, 1'b0, 32'h0, 32'd0, 4'b0011, 1'b0, "rd_w0_lo");
        xact(0, 1'b1, 1'b0, 32'h0, 32'd0, 4'b1100, 1'b0, "rd_w0_hi");

        xact(0, 1'b1, 1'b0, 32'h10, 32'd0, 4'b1111, 1'b1, "drop");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("drop_no_hit", hit[0], 0);
        end
        xact(0, 1'b1, 1'b0, 32'h14, 32'd0, 4'b0011, 1'b0, "drop_rb_lo");
        xact(0, 1'b1, 1'b0, 32'h14, 32'd0, 4'b1100, 1'b0, "drop_rb_hi");

        drive(1, 1'b0, 1'b1, 32'h20, ~m_mem[1][8], 4'hF);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("rst_mid_busy", busy[1], 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_busy_clr", busy[1], 0);
        check("rst_mid_hit", hit[1], 0);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            m_rd[i] = 0;
            m_wr[i] = 0;
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst_mid_no_hit", hit[1], 0);
        end
        xact(1, 1'b1, 1'b0, 32'h20, 32'd0, 4'b0011, 1'b0, "rst_rb_lo");
        xact(1, 1'b1, 1'b0, 32'h20, 32'd0, 4'b1100, 1'b0, "rst_rb_hi");

        xact(2, 1'b1, 1'b0, 32'h0, 32'd0, 4'b1111, 1'b0, "b2b_0");
        xact(2, 1'b1, 1'b0, 32'h4, 32'd0, 4'b1111, 1'b0, "b2b_4");
        check("b2b_rd_count", rd_count[2], c_PERF ? 2 : 0);

        for (int t = 0; t < 240; t++) begin
            d  = $urandom_range(0, NI - 1);
            p  = $urandom_range(0, 99);
            rv = (p < 50);
            wv = (p >= 50) || (p < 5);
            if ($urandom_range(0, 9) == 0) adr = $urandom();
            else                           adr = $urandom_range(0, DEPTH * 4 + 7);
            s = 4'($urandom_range(0, 15));
            while (rv && !wv && (s == 4'b0111 || s == 4'b1110)) s = 4'($urandom_range(0, 15));
            xact(d, rv, wv, adr, $urandom(), s, 1'b0, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
